// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM generator with programmable rise/fall dead-time, per-output
// polarity, per-channel enable and a global sticky fault shutdown.
module pwm_deadtime_gen #(
  parameter int unsigned NCH  = 3,
  parameter int unsigned DT_W = 8
) (
  input  logic            mclk,
  input  logic            h_reset,
  input  logic [NCH-1:0]  pwm_wfm_i,
  input  logic [NCH-1:0]  cfg_dt_enb,
  input  logic [DT_W-1:0] cfg_dt_rise,
  input  logic [DT_W-1:0] cfg_dt_fall,
  input  logic [NCH-1:0]  cfg_pol_hi,
  input  logic [NCH-1:0]  cfg_pol_lo,
  input  logic            fault_in,
  input  logic            fault_clr,
  output logic [NCH-1:0]  pwm_hi_o,
  output logic [NCH-1:0]  pwm_lo_o,
  output logic            fault_sts,
  output logic            fault_intr
);

  typedef enum logic [2:0] {
    StOff,
    StLoOn,
    StDtRise,
    StHiOn,
    StDtFall
  } state_t;

  logic [NCH-1:0]  r_in_q;
  state_t          r_state [NCH];
  logic [DT_W-1:0] r_cnt   [NCH];
  logic [NCH-1:0]  r_hi;
  logic [NCH-1:0]  r_lo;
  logic            r_fault_sts;
  logic            r_fault_intr;
  logic            w_hold_off;

  // A fault arriving this cycle forces OFF at the same edge that sets the sticky flag.
  assign w_hold_off = fault_in | r_fault_sts;

  // Single-stage sample of the incoming PWM waveforms.
  always_ff @(posedge mclk) begin
    if (h_reset) begin
      r_in_q <= '0;
    end else begin
      r_in_q <= pwm_wfm_i;
    end
  end

  // Sticky fault flag and one-cycle interrupt on its rising edge; fault beats clear.
  always_ff @(posedge mclk) begin
    if (h_reset) begin
      r_fault_sts  <= 1'b0;
      r_fault_intr <= 1'b0;
    end else begin
      r_fault_intr <= fault_in & ~r_fault_sts;
      if (fault_in) begin
        r_fault_sts <= 1'b1;
      end else if (fault_clr) begin
        r_fault_sts <= 1'b0;
      end
    end
  end

  // Per-channel dead-time FSMs with registered hi/lo decodes.
  always_ff @(posedge mclk) begin
    if (h_reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= StOff;
        r_cnt[i]   <= '0;
      end
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_hold_off || !cfg_dt_enb[i]) begin
          r_state[i] <= StOff;
          r_cnt[i]   <= '0;
          r_hi[i]    <= 1'b0;
          r_lo[i]    <= 1'b0;
        end else begin
          unique case (r_state[i])
            StOff: begin
              if (r_in_q[i]) begin
                r_state[i] <= StHiOn;
                r_hi[i]    <= 1'b1;
                r_lo[i]    <= 1'b0;
              end else begin
                r_state[i] <= StLoOn;
                r_hi[i]    <= 1'b0;
                r_lo[i]    <= 1'b1;
              end
            end
            StLoOn: begin
              if (r_in_q[i]) begin
                r_lo[i] <= 1'b0;
                if (cfg_dt_rise == '0) begin
                  r_state[i] <= StHiOn;
                  r_hi[i]    <= 1'b1;
                end else begin
                  r_state[i] <= StDtRise;
                  r_cnt[i]   <= cfg_dt_rise - 1'b1;
                  r_hi[i]    <= 1'b0;
                end
              end
            end
            StDtRise: begin
              if (!r_in_q[i]) begin
                // Pulse shorter than dead-time: fall back without touching hi.
                r_state[i] <= StLoOn;
                r_lo[i]    <= 1'b1;
                r_hi[i]    <= 1'b0;
              end else if (r_cnt[i] == '0) begin
                r_state[i] <= StHiOn;
                r_hi[i]    <= 1'b1;
                r_lo[i]    <= 1'b0;
              end else begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
              end
            end
            StHiOn: begin
              if (!r_in_q[i]) begin
                r_hi[i] <= 1'b0;
                if (cfg_dt_fall == '0) begin
                  r_state[i] <= StLoOn;
                  r_lo[i]    <= 1'b1;
                end else begin
                  r_state[i] <= StDtFall;
                  r_cnt[i]   <= cfg_dt_fall - 1'b1;
                  r_lo[i]    <= 1'b0;
                end
              end
            end
            StDtFall: begin
              if (r_in_q[i]) begin
                r_state[i] <= StHiOn;
                r_hi[i]    <= 1'b1;
                r_lo[i]    <= 1'b0;
              end else if (r_cnt[i] == '0) begin
                r_state[i] <= StLoOn;
                r_lo[i]    <= 1'b1;
                r_hi[i]    <= 1'b0;
              end else begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
              end
            end
            default: begin
              r_state[i] <= StOff;
              r_hi[i]    <= 1'b0;
              r_lo[i]    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign pwm_hi_o   = r_hi ^ cfg_pol_hi;
  assign pwm_lo_o   = r_lo ^ cfg_pol_lo;
  assign fault_sts  = r_fault_sts;
  assign fault_intr = r_fault_intr;

endmodule
